// File: rtl/register_file.sv
// Multi-port register file: DEPTH x WIDTH entries, two combinational read ports,
// one byte-masked synchronous write port, optional hardwired zero entry and write bypass.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [WIDTH/8-1:0]    byte_enable,
  input  logic [ADDR_W-1:0]     read_addr_a,
  input  logic [ADDR_W-1:0]     read_addr_b,
  output logic [WIDTH-1:0]      read_data_a,
  output logic [WIDTH-1:0]      read_data_b
);

  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_hit;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_a_raw;
  logic [WIDTH-1:0] rd_b_raw;

  // Address decode is a loop over real entries only, so out-of-range addresses
  // and the hardwired zero entry simply never match and read back as 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_hit   = 1'b0;
    wr_old   = '0;
    rd_a_raw = '0;
    rd_b_raw = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        if (write_addr == ADDR_W'(i)) begin
          wr_hit = 1'b1;
          wr_old = mem[i];
        end
        if (read_addr_a == ADDR_W'(i)) rd_a_raw = mem[i];
        if (read_addr_b == ADDR_W'(i)) rd_b_raw = mem[i];
      end
    end
  end

  always_comb begin
    wr_merged = wr_old;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_enable[b]) wr_merged[8*b +: 8] = write_data[8*b +: 8];
    end
  end

  assign wr_valid = reset && write_enable && wr_hit;

  // NOTE: the array is reset on purpose: a cleared register file is architecturally visible,
  // so it is built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: state is updated with non-blocking assignments so all reads in this edge see pre-edge values.
        if (wr_valid && write_addr == ADDR_W'(i)) mem[i] <= wr_merged;
      end
    end
  end

  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    if (reset) begin
      read_data_a = (BYPASS != 0 && wr_valid && read_addr_a == write_addr) ? wr_merged : rd_a_raw;
      read_data_b = (BYPASS != 0 && wr_valid && read_addr_b == write_addr) ? wr_merged : rd_b_raw;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: three instances (bypass, no bypass, DEPTH=16)
// share one stimulus stream; expected values go through a scoreboard queue.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [4:0]  ra;
  logic [4:0]  rb;

  logic [31:0] rda_byp, rdb_byp, rda_nob, rdb_nob, rda_d16, rdb_d16;

  register_file u_byp (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(waddr),
    .write_data(wdata), .byte_enable(be), .read_addr_a(ra), .read_addr_b(rb),
    .read_data_a(rda_byp), .read_data_b(rdb_byp)
  );

  register_file #(.BYPASS(0)) u_nob (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(waddr),
    .write_data(wdata), .byte_enable(be), .read_addr_a(ra), .read_addr_b(rb),
    .read_data_a(rda_nob), .read_data_b(rdb_nob)
  );

  register_file #(.DEPTH(16)) u_d16 (
    .clock(clock), .reset(reset), .write_enable(we), .write_addr(waddr),
    .write_data(wdata), .byte_enable(be), .read_addr_a(ra), .read_addr_b(rb),
    .read_data_a(rda_d16), .read_data_b(rdb_d16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;   // expected on the bypassing 32-entry instance
    logic [31:0] exp_b;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic [31:0] mem32 [32];
  logic [31:0] mem16 [16];
  vec_t        tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input bit is16, input bit byp, input logic [4:0] addr);
    int          depth;
    logic [31:0] cur;
    depth = is16 ? 16 : 32;
    if (!reset) return 32'h0;
    if (addr == 5'd0 || int'(addr) >= depth) return 32'h0;
    cur = is16 ? mem16[addr[3:0]] : mem32[addr];
    if (byp && we && waddr == addr) cur = merge(cur, wdata, be);
    return cur;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) mem32[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem16[i] = 32'h0;
  endfunction

  function automatic void model_commit();
    if (reset && we && waddr != 5'd0) begin
      mem32[waddr] = merge(mem32[waddr], wdata, be);
      if (waddr < 5'd16) mem16[waddr[3:0]] = merge(mem16[waddr[3:0]], wdata, be);
    end
  endfunction

  function automatic void push6(input string name,
                                input logic [31:0] a0, input logic [31:0] b0,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input logic [31:0] a2, input logic [31:0] b2);
    exp_q.push_back('{{name, ".byp.a"}, a0});
    exp_q.push_back('{{name, ".byp.b"}, b0});
    exp_q.push_back('{{name, ".nob.a"}, a1});
    exp_q.push_back('{{name, ".nob.b"}, b1});
    exp_q.push_back('{{name, ".d16.a"}, a2});
    exp_q.push_back('{{name, ".d16.b"}, b2});
  endfunction

  task automatic compare_outputs();
    logic [31:0] act [6];
    exp_t        e;
    act = '{rda_byp, rdb_byp, rda_nob, rdb_nob, rda_d16, rdb_d16};
    for (int i = 0; i < 6; i++) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty: got no entry expected one for output %0d", i);
      end else begin
        e = exp_q.pop_front();
        check(e.name, act[i], e.exp);
      end
    end
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [3:0] m,
                              input logic [4:0] a, input logic [4:0] b,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v = '{n, w, wa, wd, m, a, b, ea, eb};
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    we = v.we; waddr = v.waddr; wdata = v.wdata; be = v.be; ra = v.ra; rb = v.rb;
    @(negedge clock);
    push6(v.name, v.exp_a, v.exp_b,
          model_read(1'b0, 1'b0, ra), model_read(1'b0, 1'b0, rb),
          model_read(1'b1, 1'b1, ra), model_read(1'b1, 1'b1, rb));
    compare_outputs();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_clear();

    tbl[0]  = mk("wr_r7",     1'b1, 5'd7,  32'h12345678, 4'b1111, 5'd7,  5'd8,  32'h12345678, 32'h0);
    tbl[1]  = mk("rd_r7",     1'b0, 5'd0,  32'h0,        4'b0000, 5'd7,  5'd8,  32'h12345678, 32'h0);
    tbl[2]  = mk("mask_r7",   1'b1, 5'd7,  32'hAABBCCDD, 4'b0101, 5'd7,  5'd7,  32'h12BB56DD, 32'h12BB56DD);
    tbl[3]  = mk("rd_mask",   1'b0, 5'd0,  32'h0,        4'b0000, 5'd7,  5'd0,  32'h12BB56DD, 32'h0);
    tbl[4]  = mk("wr_r0",     1'b1, 5'd0,  32'hFFFFFFFF, 4'b1111, 5'd0,  5'd0,  32'h0,        32'h0);
    tbl[5]  = mk("rd_r0",     1'b0, 5'd0,  32'h0,        4'b0000, 5'd0,  5'd7,  32'h0,        32'h12BB56DD);
    tbl[6]  = mk("wr_r3",     1'b1, 5'd3,  32'h11111111, 4'b1111, 5'd3,  5'd31, 32'h11111111, 32'h0);
    tbl[7]  = mk("byp_r3",    1'b1, 5'd3,  32'h22222222, 4'b1111, 5'd3,  5'd3,  32'h22222222, 32'h22222222);
    tbl[8]  = mk("rd_r3",     1'b0, 5'd0,  32'h0,        4'b0000, 5'd3,  5'd7,  32'h22222222, 32'h12BB56DD);
    tbl[9]  = mk("be_none",   1'b1, 5'd3,  32'hDEADDEAD, 4'b0000, 5'd3,  5'd3,  32'h22222222, 32'h22222222);
    tbl[10] = mk("wr_r20",    1'b1, 5'd20, 32'hCAFEF00D, 4'b1111, 5'd20, 5'd4,  32'hCAFEF00D, 32'h0);
    tbl[11] = mk("rd_after20",1'b0, 5'd0,  32'h0,        4'b0000, 5'd20, 5'd4,  32'hCAFEF00D, 32'h0);
    tbl[12] = mk("wr_r4",     1'b1, 5'd4,  32'h0000BEEF, 4'b0011, 5'd4,  5'd20, 32'h0000BEEF, 32'hCAFEF00D);
    tbl[13] = mk("wr_r31",    1'b1, 5'd31, 32'hA5A5A5A5, 4'b1000, 5'd31, 5'd4,  32'hA5000000, 32'h0000BEEF);
    tbl[14] = mk("rd_r31",    1'b0, 5'd0,  32'h0,        4'b0000, 5'd31, 5'd3,  32'hA5000000, 32'h22222222);

    // Reset held low across an edge with a write pending: nothing written, outputs forced to 0.
    reset = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; be = 4'hF; ra = 5'd5; rb = 5'd5;
    @(posedge clock);
    @(negedge clock);
    push6("in_reset", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    compare_outputs();
    we = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    model_commit();
    #1;

    foreach (tbl[i]) apply_vec(tbl[i]);

    // Asynchronous clear: r5 loaded, then reset pulsed between edges.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; be = 4'hF; ra = 5'd5; rb = 5'd8;
    @(posedge clock);
    model_commit();
    #1;
    we = 1'b0;
    #2;
    push6("r5_loaded", 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
    compare_outputs();
    reset = 1'b0;
    model_clear();
    #1;
    push6("async_clear", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    compare_outputs();
    @(negedge clock);
    reset = 1'b1;
    rb = 5'd5;
    #1;
    push6("r5_after_clear", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    compare_outputs();
    @(posedge clock);
    #1;

    // Reset arriving mid-cycle while a write is pending: the write is lost.
    we = 1'b1; waddr = 5'd9; wdata = 32'h13579BDF; be = 4'hF; ra = 5'd9; rb = 5'd9;
    #2;
    push6("pend_bypass", 32'h13579BDF, 32'h13579BDF, 32'h0, 32'h0, 32'h13579BDF, 32'h13579BDF);
    compare_outputs();
    reset = 1'b0;
    model_clear();
    #1;
    push6("pend_reset", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    compare_outputs();
    @(posedge clock);
    #1;
    we = 1'b0;
    reset = 1'b1;
    #1;
    push6("pend_lost", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    compare_outputs();

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
